// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment scanner.
//   HEX_FONT  : 16-entry active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
//   SEG_A..G  : bit positions of each segment inside a {dp,g,f,e,d,c,b,a} byte
//   SEG_DP    : bit position of the decimal point inside a raw byte
//   SEG_BLANK : all segments off (active-low)
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Ascending range so that the first listed entry is digit 0.
  localparam logic [0:15][6:0] HEX_FONT = {
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to active-low segment decoder.
//   nibble : hex value 0..F
//   seg    : active-low {g,f,e,d,c,b,a}
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_FONT[nibble];

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: multiplexed common-anode seven-segment scanner.
//   clk, rst   : system clock, asynchronous active-high reset
//   div_value  : prescaler terminal count, one digit slot = div_value+1 cycles
//   din        : packed hex nibbles, nibble k drives digit k
//   dp         : per-digit decimal point, 1 = lit
//   digit_en   : per-digit enable, 0 = blanked (slot still consumed)
//   raw_mode   : 1 = drive segments from raw bytes instead of the hex font
//   raw        : byte k = {dp,g,f,e,d,c,b,a}, 1 = lit
//   bright     : PWM duty level, all-ones = always on, 0 = dark
//   an         : active-low anodes
//   seg        : active-low {g,f,e,d,c,b,a}
//   dp_o       : active-low decimal point
//   frame_o    : one-cycle pulse when the scan wraps to digit 0
// All display inputs are captured into shadow registers only at the frame
// wrap, so a frame is always drawn from one consistent snapshot.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int DIV_W    = 32,
  parameter int BRIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIV_W-1:0]      div_value,
  input  logic [4*N_DIGITS-1:0] din,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  raw_mode,
  input  logic [8*N_DIGITS-1:0] raw,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp_o,
  output logic                  frame_o
);

  localparam int                 IDX_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(N_DIGITS - 1);
  localparam logic [BRIGHT_W-1:0] BRIGHT_FULL = '1;

  // Scan state
  logic [DIV_W-1:0]    pcnt_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [IDX_W-1:0]    idx_next;
  logic [BRIGHT_W-1:0] pwm_reg;
  logic                tick;
  logic                wrap;

  // Per-frame snapshot of the display inputs
  logic [4*N_DIGITS-1:0] din_sh_reg;
  logic [N_DIGITS-1:0]   dp_sh_reg;
  logic [N_DIGITS-1:0]   en_sh_reg;
  logic                  raw_mode_sh_reg;
  logic [8*N_DIGITS-1:0] raw_sh_reg;

  // Output registers
  logic [N_DIGITS-1:0] an_reg,   an_next;
  logic [6:0]          seg_reg,  seg_next;
  logic                dp_o_reg, dp_o_next;
  logic                frame_reg;

  // Per-digit views of the snapshot
  logic [3:0] nibble_arr [N_DIGITS];
  logic [7:0] raw_arr    [N_DIGITS];

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    assign nibble_arr[gi] = din_sh_reg[4*gi +: 4];
    assign raw_arr[gi]    = raw_sh_reg[8*gi +: 8];
  end

  logic [3:0] cur_nibble;
  logic [7:0] cur_raw;
  logic [6:0] font_seg;
  logic       pwm_on;

  assign cur_nibble = nibble_arr[idx_reg];
  assign cur_raw    = raw_arr[idx_reg];

  seg_hex_decode u_hex_decode (
    .nibble (cur_nibble),
    .seg    (font_seg)
  );

  // >= rather than == so that lowering div_value below the running count
  // terminates the current slot on the next edge instead of wrapping DIV_W.
  assign tick = (pcnt_reg >= div_value);
  assign wrap = tick && (idx_reg == LAST_IDX);

  always_comb begin
    idx_next = idx_reg;
    if (tick) begin
      idx_next = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
    end
  end

  assign pwm_on = (bright == BRIGHT_FULL) || (pwm_reg < bright);

  // Output selection uses the current idx and snapshot; the registered
  // outputs therefore follow a tick by one cycle, with anode and segments
  // switching together.
  always_comb begin
    an_next = '1;
    if (pwm_on && en_sh_reg[idx_reg]) begin
      an_next[idx_reg] = 1'b0;
    end
    if (raw_mode_sh_reg) begin
      seg_next  = ~cur_raw[SEG_G:SEG_A];
      dp_o_next = ~cur_raw[SEG_DP];
    end else begin
      seg_next  = font_seg;
      dp_o_next = ~dp_sh_reg[idx_reg];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_reg        <= '0;
      idx_reg         <= LAST_IDX;
      pwm_reg         <= '0;
      din_sh_reg      <= '0;
      dp_sh_reg       <= '0;
      en_sh_reg       <= '0;
      raw_mode_sh_reg <= 1'b0;
      raw_sh_reg      <= '0;
      an_reg          <= '1;
      seg_reg         <= SEG_BLANK;
      dp_o_reg        <= 1'b1;
      frame_reg       <= 1'b0;
    end else begin
      pcnt_reg  <= tick ? '0 : pcnt_reg + 1'b1;
      idx_reg   <= idx_next;
      pwm_reg   <= pwm_reg + 1'b1;
      frame_reg <= wrap;
      if (wrap) begin
        din_sh_reg      <= din;
        dp_sh_reg       <= dp;
        en_sh_reg       <= digit_en;
        raw_mode_sh_reg <= raw_mode;
        raw_sh_reg      <= raw;
      end
      an_reg   <= an_next;
      seg_reg  <= seg_next;
      dp_o_reg <= dp_o_next;
    end
  end

  assign an      = an_reg;
  assign seg     = seg_reg;
  assign dp_o    = dp_o_reg;
  assign frame_o = frame_reg;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: scoreboard bench for seg_scan_mux (N_DIGITS=8).
// Stimulus pushes expected values tagged with the cycle (edges since reset
// release) on which they must be visible; a monitor pops and compares them.
module tb_seg_scan_mux;

  localparam int K_AN  = 0;
  localparam int K_SEG = 1;
  localparam int K_DP  = 2;
  localparam int K_FR  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] div_value = 32'd3;
  logic [31:0] din = 32'h01234567;
  logic [7:0]  dp = 8'h00;
  logic [7:0]  digit_en = 8'hFF;
  logic        raw_mode = 1'b0;
  logic [63:0] raw = 64'h0;
  logic [3:0]  bright = 4'hF;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp_o;
  logic        frame_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];

  seg_scan_mux #(.N_DIGITS(8), .DIV_W(32), .BRIGHT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .div_value (div_value),
    .din       (din),
    .dp        (dp),
    .digit_en  (digit_en),
    .raw_mode  (raw_mode),
    .raw       (raw),
    .bright    (bright),
    .an        (an),
    .seg       (seg),
    .dp_o      (dp_o),
    .frame_o   (frame_o)
  );

  always #5 clk = ~clk;

  // Edge counter since reset release: after edge n, cyc == n.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [6:0] font(input int v);
    case (v)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001;
      14: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  task automatic push(input int c, input int k, input logic [15:0] v, input string t);
    exp_t e;
    e.cyc = c; e.kind = k; e.exp = v; e.tag = t;
    sb.push_back(e);
  endtask

  // Monitor: compare every entry whose cycle has arrived.
  exp_t        mon_e;
  logic [15:0] mon_act;
  always @(negedge clk) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        mon_e = sb.pop_front();
        case (mon_e.kind)
          K_AN:    mon_act = {8'h00, an};
          K_SEG:   mon_act = {9'h000, seg};
          K_DP:    mon_act = {15'h0000, dp_o};
          default: mon_act = {15'h0000, frame_o};
        endcase
        checks++;
        if (mon_e.cyc != cyc) begin
          errors++;
          $display("FAIL %s missed: due cyc=%0d seen cyc=%0d", mon_e.tag, mon_e.cyc, cyc);
        end else if (mon_act !== mon_e.exp) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h want=%h", mon_e.tag, cyc, mon_act, mon_e.exp);
        end else begin
          $display("ok   %s cyc=%0d val=%h", mon_e.tag, cyc, mon_act);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end else begin
      $display("ok   %s val=%h", name, act);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc < target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < target) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc timeout got=%0d want=%0d", cyc, target);
    end
  endtask

  task automatic drain(input int target, input string name);
    wait_cyc(target);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s drain got=%0d pending want=0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic [7:0] a;
    // Reset state while rst is held
    #12;
    check("rst_an",    {8'h00, an},      16'h00FF);
    check("rst_seg",   {9'h000, seg},    16'h007F);
    check("rst_dp",    {15'h0, dp_o},    16'h0001);
    check("rst_frame", {15'h0, frame_o}, 16'h0000);

    // Hex scan: walking anode, font per nibble, frame every 32 cycles
    do_reset();
    push(4, K_FR, 16'd1, "hex_frame_first");
    push(5, K_FR, 16'd0, "hex_frame_low");
    for (int d = 0; d < 8; d++) begin
      a = ~(8'h01 << d);
      push(6 + 4*d, K_AN,  {8'h00, a},           $sformatf("hex_an_d%0d", d));
      push(6 + 4*d, K_SEG, {9'h000, font(7 - d)}, $sformatf("hex_seg_d%0d", d));
      push(6 + 4*d, K_DP,  16'd1,                $sformatf("hex_dp_d%0d", d));
    end
    push(35, K_FR, 16'd0, "hex_frame_pre");
    push(36, K_FR, 16'd1, "hex_frame_second");
    drain(37, "hex");

    // Snapshot: din changed mid-frame only shows after the next frame_o
    do_reset();
    push(14, K_SEG, {9'h000, font(5)},  "snap_d2_old");
    push(34, K_SEG, {9'h000, font(0)},  "snap_d7_old");
    push(36, K_SEG, {9'h000, font(0)},  "snap_at_frame");
    push(37, K_SEG, {9'h000, font(15)}, "snap_d0_new");
    push(37, K_AN,  16'h00FE,           "snap_an_d0");
    wait_cyc(10);
    din = 32'h89ABCDEF;
    drain(38, "snap");

    // Blanking and decimal point
    din = 32'h01234567; digit_en = 8'hFE; dp = 8'h02;
    do_reset();
    push(6,  K_AN,  16'h00FF,           "blank_an_d0");
    push(6,  K_DP,  16'd1,              "blank_dp_d0");
    push(10, K_AN,  16'h00FD,           "blank_an_d1");
    push(10, K_DP,  16'd0,              "blank_dp_d1");
    push(10, K_SEG, {9'h000, font(6)},  "blank_seg_d1");
    drain(11, "blank");

    // Raw mode
    digit_en = 8'hFF; dp = 8'h00; raw_mode = 1'b1; raw = 64'h0000_0000_0000_0689;
    do_reset();
    push(6,  K_SEG, 16'h0076, "raw_seg_d0");
    push(6,  K_DP,  16'd0,    "raw_dp_d0");
    push(10, K_SEG, 16'h0079, "raw_seg_d1");
    push(10, K_DP,  16'd1,    "raw_dp_d1");
    drain(11, "raw");

    // Brightness: 4/16 duty inside digit 0 slot, then dark with bright=0
    raw_mode = 1'b0; bright = 4'd4; div_value = 32'd63;
    do_reset();
    for (int m = 65; m <= 96; m++) begin
      push(m, K_AN, (((m - 1) % 16) < 4) ? 16'h00FE : 16'h00FF, $sformatf("pwm4_c%0d", m));
    end
    for (int m = 98; m <= 129; m++) begin
      push(m, K_AN, 16'h00FF, $sformatf("pwm0_c%0d", m));
    end
    wait_cyc(96);
    bright = 4'd0;
    drain(130, "pwm");

    // Asynchronous reset mid-slot, then clean restart
    bright = 4'hF; div_value = 32'd3;
    do_reset();
    wait_cyc(9);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_an",    {8'h00, an},      16'h00FF);
    check("arst_seg",   {9'h000, seg},    16'h007F);
    check("arst_dp",    {15'h0, dp_o},    16'h0001);
    check("arst_frame", {15'h0, frame_o}, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push(3, K_AN, 16'h00FF, "arst_no_partial");
    push(4, K_FR, 16'd1,    "arst_first_frame");
    drain(5, "arst");

    // Lowering div_value below pcnt forces a tick on the next edge
    div_value = 32'd100;
    do_reset();
    push(50, K_FR, 16'd0,    "div_pre");
    push(51, K_FR, 16'd1,    "div_forced_tick");
    push(52, K_AN, 16'h00FE, "div_d0");
    push(55, K_AN, 16'h00FD, "div_d1");
    wait_cyc(50);
    div_value = 32'd2;
    drain(56, "div");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised multiplexed seven-segment scanner, the successor of the fixed 8-digit display driver. It scans `N_DIGITS` common-anode digits from a packed hex word or raw segment bytes, with per-digit blanking, decimal points and PWM brightness. Inputs are snapshotted once per frame so the display never tears. It sits between the test/autotest logic and the board anode/segment pins.

## Interface
- `N_DIGITS`, 8: number of digits scanned (1..16).
- `DIV_W`, 32: width of `div_value`.
- `BRIGHT_W`, 4: brightness resolution in bits.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `div_value` in DIV_W: prescaler terminal count. Digit slot = `div_value`+1 cycles.
- `din` in 4*N_DIGITS: hex nibbles. Nibble k drives digit k.
- `dp` in N_DIGITS: decimal point per digit, 1 = lit.
- `digit_en` in N_DIGITS: 0 = digit blanked.
- `raw_mode` in 1: 1 = use `raw` instead of the hex font.
- `raw` in 8*N_DIGITS: byte k = {dp,g,f,e,d,c,b,a}, 1 = lit.
- `bright` in BRIGHT_W: duty level. All-ones = 100 %.
- `an` out N_DIGITS: anodes, active-low.
- `seg` out 7: {g,f,e,d,c,b,a}, active-low.
- `dp_o` out 1: decimal point, active-low.
- `frame_o` out 1: one-cycle pulse at each frame start.

## Operation
- Prescaler `pcnt` (DIV_W bits):
  - `tick` = (`pcnt` >= `div_value`).
  - On tick, `pcnt` <= 0; otherwise `pcnt` +1.
  - `div_value` = 0 gives a tick every cycle.
  - Lowering `div_value` below `pcnt` forces a tick on the next cycle.
- Digit index `idx`, ceil(log2 N_DIGITS) bits:
  - Reset value N_DIGITS-1.
  - On tick, `idx` <= (`idx` == N_DIGITS-1) ? 0 : `idx`+1.
- Frame snapshot:
  - On a tick where `idx` wraps to 0, load `din`, `dp`, `digit_en`, `raw_mode` and `raw` into shadow registers.
  - `frame_o` pulses on the same cycle.
  - Input changes mid-frame are invisible until the next wrap.
- Segment selection for digit `idx`, from the shadow copy:
  - Hex mode: `seg` = font(nibble), `dp_o` = ~dp[idx].
  - Raw mode: `seg` = ~raw[idx][6:0], `dp_o` = ~raw[idx][7].
- PWM:
  - Free-running `pwm` counter, BRIGHT_W bits, +1 every clock, wraps.
  - `on` = (`bright` == all-ones) || (`pwm` < `bright`).
  - `bright` = 0 keeps the display dark.
- Anode: `an` = all-ones except bit `idx` = 0, and only when `on` && shadow `digit_en[idx]`.
- Blanked digits still consume their slot, so the scan rate stays uniform.
- Hex font, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110

## Timing
- Reset values: `an` = all ones, `seg` = 7'h7F, `dp_o` = 1, `frame_o` = 0, `pcnt` = 0, `pwm` = 0, shadows = 0, `idx` = N_DIGITS-1.
- First tick comes `div_value`+1 cycles after reset release. That tick moves `idx` to 0, loads the shadows and pulses `frame_o`.
- `an`, `seg` and `dp_o` are registered: they reflect a new `idx` and shadows one cycle after the tick.
- PWM gating has one cycle latency from `pwm`/`bright` to `an`.
- Segments and anode always switch in the same cycle, so there is no ghosting skew.
- Reset mid-frame returns all state to reset values immediately. There is no partial frame after release.
- Frame period = N_DIGITS × (`div_value`+1) cycles, for a constant `div_value`.

## Structure
- Package `seg_pkg` holds the 16-entry hex font constant array, the segment bit-order localparams and the `SEG_BLANK` = 7'h7F constant.
- Sub-module `seg_hex_decode` is the combinational nibble-to-segment decoder using `seg_pkg`.
- The top holds the prescaler, index, shadow registers, PWM and output registers.

## Test plan
- **Hex scan:** N=8, `div_value`=3, `din`=32'h01234567, all digits enabled, `bright`=F.
  - Each 4-cycle slot drives `an` with a single 0 walking bit0→bit7.
  - Digit 0 shows `seg`=7'b1111000 ("7"); digit 7 shows 7'b1000000.
  - `frame_o` pulses every 32 cycles.
- **Snapshot:** change `din` mid-frame. `seg` is unchanged until the cycle after the next `frame_o`.
- **Blanking and dp:** `digit_en`=8'hFE, `dp`=8'h02.
  - Digit 0 slot: `an`=all ones.
  - Digit 1 slot: `dp_o`=0.
- **Raw mode:** `raw_mode`=1, byte 0 = 8'h89.
  - Digit 0 gives `seg`=7'b1110110 and `dp_o`=0.
- **Brightness:** `bright`=4, `div_value`=63.
  - `an` is active for exactly 4 of every 16 cycles within a slot.
  - `bright`=0 gives `an` always all ones.
- **Reset/divider:** assert `rst` mid-slot; all outputs reach reset values asynchronously.
  - `div_value` 100→2 with `pcnt`=50 gives a tick on the next cycle.
